// File: rtl/cp0_int_timer_ctrl_if.sv
// CP0 interrupt/timer controller bundle: status inputs, MTC0 port,
// ack handshake from writeback and the timer/interrupt outputs.
interface cp0_int_timer_ctrl_if;
  logic [5:0]  ext_int;
  logic        status_ie;
  logic        status_exl;
  logic        status_erl;
  logic [7:0]  status_im;
  logic [1:0]  sw_ip;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        int_ack;
  logic [31:0] count;
  logic [31:0] compare;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic        int_req;

  modport master (
    output ext_int, status_ie, status_exl, status_erl,
    output status_im, sw_ip, cp0_we, cp0_waddr,
    output cp0_wdata, int_ack,
    input  count, compare, cause_ti, cause_ip, int_req
  );

  modport slave (
    input  ext_int, status_ie, status_exl, status_erl,
    input  status_im, sw_ip, cp0_we, cp0_waddr,
    input  cp0_wdata, int_ack,
    output count, compare, cause_ti, cause_ip, int_req
  );
endinterface

// File: rtl/cp0_int_timer_ctrl.sv
// CP0 Count/Compare timer, Cause.TI, ext_int synchroniser and the
// Int request/ack handshake towards writeback.
module cp0_int_timer_ctrl (
  input logic              clk,
  input logic              resetn,
  cp0_int_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  meta;
  logic [5:0]  sync;
  logic        tick;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_inc;
  logic        cause_ti;
  logic        count_wr;
  logic        cmp_wr;
  logic        inc;
  logic        pending;
  logic [7:0]  cause_ip;

  assign count_wr  = bus.cp0_we && (bus.cp0_waddr == 5'd9);
  assign cmp_wr    = bus.cp0_we && (bus.cp0_waddr == 5'd11);
  assign inc       = tick && !count_wr;
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta     <= '0;
      sync     <= '0;
      tick     <= 1'b0;
      count    <= '0;
      compare  <= '0;
      cause_ti <= 1'b0;
    end else begin
      meta <= bus.ext_int;
      sync <= meta;
      if (count_wr) begin
        count <= bus.cp0_wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count_inc;
      end
      // a Compare write clears TI even if this edge would match
      if (cmp_wr) begin
        compare  <= bus.cp0_wdata;
        cause_ti <= 1'b0;
      end else if (inc && (count_inc == compare)) begin
        cause_ti <= 1'b1;
      end
    end
  end

  assign cause_ip = {sync[5] | cause_ti, sync[4:0], bus.sw_ip};
  assign pending  = (|(cause_ip & bus.status_im)) & bus.status_ie &
                    ~bus.status_exl & ~bus.status_erl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pending) state_nxt = REQ;
      REQ: begin
        if (bus.int_ack)   state_nxt = WAIT;
        else if (!pending) state_nxt = IDLE;
      end
      WAIT: if (bus.status_exl || bus.status_erl) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.int_req  = (state == REQ);
    bus.count    = count;
    bus.compare  = compare;
    bus.cause_ti = cause_ti;
    bus.cause_ip = cause_ip;
  end

endmodule

// File: doc/cp0_int_timer_ctrl.md
# cp0_int_timer_ctrl

Interrupt and timer controller for CP0, sitting beside the writeback stage. It owns the Count/Compare timer and the Cause.TI flag, and synchronises the six hardware interrupt lines. It qualifies pending interrupts against Status and raises a request/acknowledge handshake to writeback, so that an Int exception is taken at exactly one instruction boundary. MTC0 writes to Count (reg 9) and Compare (reg 11) from writeback are routed here.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- ext_int  in  6  asynchronous hardware interrupt lines, level-sensitive
- status_ie, status_exl, status_erl  in  1 each  current CP0 Status bits
- status_im  in  8  Status.IM
- sw_ip  in  2  Cause.IP[1:0] (software interrupts) from the CP0 register file
- cp0_we  in  1  MTC0 commit this cycle
- cp0_waddr  in  5  MTC0 destination register number
- cp0_wdata  in  32  MTC0 data
- int_ack  in  1  writeback took the Int exception this cycle
- count  out  32  CP0 Count
- compare  out  32  CP0 Compare
- cause_ti  out  1  Cause.TI
- cause_ip  out  8  Cause.IP view: {sync[5] | cause_ti, sync[4:0], sw_ip}
- int_req  out  1  registered interrupt request to writeback

## Operation
- **Synchroniser:** two flops per ext_int bit. `sync` is the second stage. No edge detection; a line is pending while it is held high.
- **Tick:**
  - 1-bit `tick` toggles every cycle.
  - Count increments (mod 2^32) in cycles where tick==1, so Count advances every second cycle.
- **MTC0 reg 9:**
  - count <= cp0_wdata and tick <= 0.
  - Takes priority over the increment in the same cycle.
  - Never sets TI.
- **MTC0 reg 11:** compare <= cp0_wdata and cause_ti <= 0. Clearing takes priority over a same-cycle match.
- **TI set:** when an increment occurs and (count+1) mod 2^32 == compare. This includes the wrap from 0xFFFFFFFF to 0 when compare==0. TI is sticky until the next Compare write.
- **Other MTC0:** writes to any other cp0_waddr are ignored here.
- **pending:** |(cause_ip & status_im) & status_ie & !status_exl & !status_erl. This is combinational from registered sources.
- **FSM:**
  - IDLE: pending -> REQ.
  - REQ: int_ack -> WAIT; else !pending -> IDLE (request withdrawn, e.g. the line dropped or IE was cleared by MTC0); else stay.
  - WAIT: status_exl | status_erl -> IDLE; else stay. WAIT blocks a second request while the EXL update from the acknowledged exception propagates.
  - int_req is registered: it is 1 exactly while state==REQ.
- **Spurious ack:** int_ack outside REQ is ignored.

## Timing
- **Reset** (asynchronous, any time including mid-handshake): all outputs and state go to zero or IDLE.
  - Values: count=0, compare=0, cause_ti=0, tick=0, sync flops=0, state=IDLE, int_req=0.
  - cause_ip therefore reflects only sw_ip.
- **ext_int latency:**
  - ext_int rising before edge k: sync high after edge k+1.
  - int_req high after edge k+2, provided the line is enabled and unmasked.
- **Timer latency:** when the incrementing edge makes count==compare, cause_ti is high after that same edge. int_req follows one edge later.
- **Handshake:**
  - int_req falls on the edge after int_ack is sampled high.
  - int_req is not reasserted before status_exl or status_erl has been observed high.
- **Count/Compare write latency:** an MTC0 write is visible on count/compare after its edge. The increment resumes two cycles after a Count write.

## Test plan
- **Reset and counting:** release resetn, let 10 cycles elapse -> count==5, cause_ti=0, int_req=0. Assert resetn low mid-count -> count=0 immediately.
- **Timer interrupt:**
  - Setup: MTC0 compare=3; status_ie=1, im[7]=1, exl=0.
  - Required: cause_ti rises on the edge count becomes 3, with int_req one edge later.
  - Then int_ack, then exl=1: int_req drops and stays low.
  - Then MTC0 compare -> cause_ti=0.
- **Wrap-around:** MTC0 count=0xFFFFFFFE, compare=0 -> TI sets when count wraps to 0.
- **External line:** pulse ext_int[2]=1 with im[4]=1 -> int_req high two edges after the synchroniser captures. Drop ext_int[2] before ack -> int_req withdraws, FSM returns to IDLE.
- **Masking and priority:**
  - With exl=1, or ie=0, or im=0 -> int_req never asserts.
  - Same-cycle Compare write and match -> cause_ti stays 0.
  - Same-cycle Count write and increment -> count==wdata.
- **Software interrupt:** sw_ip=2'b01, im[0]=1, ie=1 -> int_req on the next edge. Ack while WAIT stays entered until exl=1; no double request.
